// File: rtl/spi_master_reader.sv
// SPI mode-0 read master: sends one address byte, then clocks in N data bytes
// while shifting 0x00 out, strobing each received byte on rx_valid.
module spi_master_reader #(
  parameter int HALF_PERIOD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        sclk,
  output logic        ssel,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [8:0] HP_LAST  = 9'(HALF_PERIOD - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * HALF_PERIOD - 1);

  state_t      state;
  state_t      state_nx;
  logic [8:0]  tick;
  logic [2:0]  bit_cnt;
  logic [16:0] bytes_left;
  logic        addr_phase;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic        miso_p0;
  logic        miso_p1;
  logic        byte_end_p0;

  logic        accept;
  logic        tick_end;
  logic        rise;
  logic        fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    tick_end = (state == GAP) ? (tick == GAP_LAST) : (tick == HP_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (tick_end) state_nx = SHIFT;
      end
      SHIFT: begin
        if (tick_end) begin
          rise = !sclk;
          fall = sclk;
          if (sclk && (bit_cnt == 3'd0) && (bytes_left == 17'd1)) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (tick_end) state_nx = GAP;
      end
      GAP: begin
        if (tick_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and port registers; a reset drops the bus to idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= '0;
      bit_cnt     <= '0;
      bytes_left  <= '0;
      addr_phase  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sclk        <= 1'b0;
      ssel        <= 1'b1;
      mosi        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      byte_end_p0 <= 1'b0;
    end else begin
      done        <= 1'b0;
      byte_end_p0 <= 1'b0;
      rx_valid    <= byte_end_p0;
      if (byte_end_p0) rx_data <= rx_shift;

      if ((state == IDLE) || tick_end) tick <= '0;
      else                             tick <= tick + 9'd1;

      if (accept) begin
        busy       <= 1'b1;
        bytes_left <= {1'b0, byte_count} + 17'd1;
        bit_cnt    <= '0;
        addr_phase <= 1'b1;
        ssel       <= 1'b0;
        mosi       <= start_addr[7];
      end

      if (rise) begin
        sclk    <= 1'b1;
        bit_cnt <= bit_cnt + 3'd1;
        if ((bit_cnt == 3'd7) && !addr_phase) byte_end_p0 <= 1'b1;
      end

      // Falling edge: bit_cnt back at 0 means a whole byte has gone by.
      if (fall) begin
        sclk <= 1'b0;
        if (bit_cnt == 3'd0) begin
          bytes_left <= bytes_left - 17'd1;
          addr_phase <= 1'b0;
          mosi       <= 1'b0;
        end else begin
          mosi <= tx_shift[6];
        end
      end

      if ((state == HOLD) && tick_end) begin
        ssel <= 1'b1;
        mosi <= 1'b0;
      end

      if ((state == GAP) && tick_end) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Data path: miso synchroniser and shift registers, no reset needed.
  always_ff @(posedge clk) begin
    miso_p0 <= miso;
    miso_p1 <= miso_p0;
    if (accept)    tx_shift <= start_addr;
    else if (fall) tx_shift <= (bit_cnt == 3'd0) ? 8'h00 : {tx_shift[6:0], 1'b0};
    if (rise)      rx_shift <= {rx_shift[6:0], miso_p1};
  end

endmodule

// File: tb/tb_spi_master_reader.sv
// Bench for spi_master_reader: transaction-level model plus a behavioural SPI
// slave that answers from a response list or from a memory with mem[i]=i.
module tb_spi_master_reader;
  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [15:0] byte_count;
  logic        busy, done, rx_valid, sclk, ssel, mosi, miso;
  logic [7:0]  rx_data;

  spi_master_reader #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .rx_data(rx_data),
    .rx_valid(rx_valid), .sclk(sclk), .ssel(ssel), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int cyc = 0, last_evt = 0, rises = 0, rv_due = -5, done_due = -5;
  int m_count = 0, done_cnt = 0, last_rises = 0;
  bit mon_en = 1'b0, in_txn = 1'b0, exp_busy = 1'b0, p_sclk = 1'b0, p_ssel = 1'b1;
  bit acc, exp_done, exp_rv, st_s = 1'b0, slave_mode = 1'b0;
  logic [7:0]  m_addr = 8'h00, hold_rx = 8'h00, mosi_cap = 8'h00, last_mosi = 8'h00, a_s = 8'h00;
  logic [15:0] c_s = 16'h0;
  logic [7:0]  exp_rx[$];
  logic [7:0]  got_rx[$];
  logic [7:0]  lit[8];
  logic [7:0]  resp[4];

  // slave state
  bit   s_sclk = 1'b0;
  int   s_bits = 0, s_k = 0;
  logic [7:0] s_in = 8'h00, s_out = 8'hB6, s_addr = 8'h00;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // what the DUT sampled on each rising clk edge
  initial forever begin
    @(posedge clk);
    st_s = start;
    a_s  = start_addr;
    c_s  = byte_count;
  end

  // SPI slave: samples mosi on sclk rise, updates miso after sclk fall
  initial forever begin
    @(negedge clk);
    if (ssel) begin
      s_bits = 0;
      s_k    = 0;
      s_out  = 8'hB6;
      miso   = 1'b1;
    end else begin
      if (sclk && !s_sclk) begin
        s_in = {s_in[6:0], mosi};
        s_bits++;
      end
      if (!sclk && s_sclk) begin
        if (s_bits % 8 == 0) begin
          if (s_bits == 8) s_addr = s_in;
          s_out = slave_mode ? 8'(s_addr + s_k) : ((s_k < 4) ? resp[s_k] : 8'h00);
          s_k++;
        end else begin
          s_out = {s_out[6:0], 1'b0};
        end
        miso = s_out[7];
      end
    end
    s_sclk = sclk;
  end

  // compare process
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      in_txn = 1'b0; exp_busy = 1'b0; hold_rx = 8'h00; exp_rx.delete();
      rv_due = -5; done_due = -5; p_sclk = 1'b0; p_ssel = 1'b1;
    end else begin
      cyc++;
      acc      = st_s && !exp_busy;
      exp_done = in_txn && (cyc == done_due);
      if (exp_done) begin
        exp_busy = 1'b0; in_txn = 1'b0; last_rises = rises; last_mosi = mosi_cap;
      end
      if (acc) begin
        exp_busy = 1'b1; in_txn = 1'b1; rises = 0; mosi_cap = 8'h00;
        m_addr = a_s; m_count = int'(c_s); done_due = -5; last_evt = cyc;
        chk("ssel_on_start", ssel, 0);
      end
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (!in_txn) chk("ssel_idle", ssel, 1);
      if (in_txn && !acc) begin
        if (sclk != p_sclk) begin
          chk("half_period", cyc - last_evt, (rises == 0) ? 2 * HP : HP);
          last_evt = cyc;
          chk("ssel_in_shift", ssel, 0);
          if (sclk) begin
            chk("mosi_bit", mosi, (rises < 8) ? m_addr[7 - rises] : 1'b0);
            if (rises < 8) mosi_cap = {mosi_cap[6:0], mosi};
            rises++;
            if (rises > 8 && rises % 8 == 0) rv_due = cyc + 1;
          end
        end
        if (ssel && !p_ssel) begin
          chk("hold_len", cyc - last_evt, HP);
          chk("rises_total", rises, 8 * (m_count + 1));
          done_due = cyc + 2 * HP;
        end
      end
      exp_rv = (cyc == rv_due);
      chk("rx_valid", rx_valid, exp_rv);
      if (rx_valid) got_rx.push_back(rx_data);
      if (exp_rv) begin
        if (exp_rx.size() == 0) chk("rx_expected_left", 0, 1);
        else hold_rx = exp_rx.pop_front();
      end
      chk("rx_data", rx_data, hold_rx);
      if (ssel) begin
        chk("sclk_idle", sclk, 0);
        chk("mosi_idle", mosi, 0);
      end
      p_sclk = sclk;
      p_ssel = ssel;
    end
  end

  task automatic start_txn(logic [7:0] a, logic [15:0] n);
    for (int k = 0; k < int'(n); k++)
      exp_rx.push_back(slave_mode ? 8'(a + k) : resp[k]);
    start      = 1'b1;
    start_addr = a;
    byte_count = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(int n);
    int  lim;
    bit  seen;
    lim  = (n + 1) * 16 * HP + 8 * HP + 100;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_txn(string tag, int exp_rises, logic [7:0] exp_addr, int n, int n_done);
    repeat (4) @(negedge clk);
    chk({tag, "_rises"}, last_rises, exp_rises);
    chk({tag, "_addr_bits"}, last_mosi, exp_addr);
    chk({tag, "_done_pulses"}, done_cnt, n_done);
    chk({tag, "_rx_count"}, got_rx.size(), n);
    for (int i = 0; i < n && i < got_rx.size(); i++)
      chk($sformatf("%s_rx%0d", tag, i), got_rx[i], lit[i]);
  endtask

  task automatic run_txn(logic [7:0] a, logic [15:0] n);
    got_rx.delete();
    done_cnt = 0;
    start_txn(a, n);
    wait_done(int'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; start_addr = 8'h00; byte_count = 16'h0;
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
    for (int i = 0; i < 8; i++) lit[i] = 8'h00;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_sclk", sclk, 0);
    chk("rst_ssel", ssel, 1);
    chk("rst_mosi", mosi, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // idle with no start
    repeat (100) @(posedge clk);
    #1;

    // address byte only
    slave_mode = 1'b0;
    run_txn(8'hA5, 16'd0);
    check_txn("t2", 8, 8'hA5, 0, 1);

    // fixed responses
    resp[0] = 8'h3C; resp[1] = 8'hC3; resp[2] = 8'h00; resp[3] = 8'hFF;
    lit[0] = 8'h3C; lit[1] = 8'hC3; lit[2] = 8'h00; lit[3] = 8'hFF;
    run_txn(8'h10, 16'd4);
    check_txn("t3", 40, 8'h10, 4, 1);

    // memory slave mem[i]=i
    slave_mode = 1'b1;
    lit[0] = 8'h20; lit[1] = 8'h21; lit[2] = 8'h22;
    run_txn(8'h20, 16'd3);
    check_txn("t4", 32, 8'h20, 3, 1);

    // start while busy is dropped
    got_rx.delete();
    done_cnt = 0;
    @(posedge clk);
    #1 start_txn(8'h42, 16'd2);
    repeat (60) @(posedge clk);
    #1 start = 1'b1; start_addr = 8'hFF; byte_count = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2);
    lit[0] = 8'h42; lit[1] = 8'h43;
    check_txn("t5", 24, 8'h42, 2, 1);
    repeat (100) @(posedge clk);
    #1 chk("t5_single_done", done_cnt, 1);

    // back-to-back: second start in the done cycle
    got_rx.delete();
    done_cnt = 0;
    start_txn(8'h05, 16'd1);
    wait_done(1);
    start_txn(8'h80, 16'd1);
    wait_done(1);
    lit[0] = 8'h05; lit[1] = 8'h80;
    check_txn("t7", 16, 8'h80, 2, 2);

    // reset mid-byte with sclk high
    got_rx.delete();
    done_cnt = 0;
    @(posedge clk);
    #1 start_txn(8'h30, 16'd8);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (rises >= 20 && sclk) hit = 1'b1;
      end
      if (!hit) chk("t6_reach_mid_byte", 0, 1);
    end
    #2 mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_abort_ssel", ssel, 1);
    chk("t6_abort_sclk", sclk, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_rx_valid", rx_valid, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_done_in_reset", done, 0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (50) @(posedge clk);
    #1 chk("t6_no_done_after_abort", done_cnt, 0);
    for (int i = 0; i < 8; i++) lit[i] = 8'(8'h30 + i);
    run_txn(8'h30, 16'd8);
    check_txn("t6", 72, 8'h30, 8, 1);

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
